// File: rtl/demux_destino_pkg.sv
// Shared transmit-layer constants for the destination demux.
// Holds the default word width, per-destination FIFO depth, almost-full
// threshold and the index of the destination bit inside a word.
package demux_destino_pkg;

  localparam int DATA_W_DEF    = 6;
  localparam int DEPTH_DEF     = 4;
  localparam int AF_THRESH_DEF = 3;
  localparam int DEST_BIT      = 4;

endpackage

// File: rtl/demux_destino_fifo.sv
// fifo_destino: single synchronous FIFO with registered read port,
// occupancy flags and sticky overflow/underflow errors.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   push_i, data_i     - write request and word
//   pop_i              - read request
//   data_o, valid_o    - registered read word and its valid strobe
//   empty_o, full_o, almost_full_o - flags decoded from the registered count
//   overflow_o, underflow_o        - sticky error flags
module fifo_destino
  import demux_destino_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              pop_ok, push_ok;

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign almost_full_o = (count_q >= CNT_W'(AF_THRESH));

  // A pop only succeeds on stored data (no bypass of a same-cycle push);
  // a push into a full FIFO is accepted only when a pop frees a slot.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    out_d    = out_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q || (push_i && !push_ok);
    udf_d    = udf_q || (pop_i && !pop_ok);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      out_d    = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is left uninitialised; the reset pointers make old words unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o      = out_q;
  assign valid_o     = valid_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: rtl/demux_destino.sv
// demux_destino: routes each valid word to one of two destination FIFOs
// (D0 / D1) selected by destiny, and merges their sticky error flags.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   data_in, valid_in, destiny - incoming word, its valid, target select
//   pop_D0, pop_D1             - consumer read requests
//   Dx_out, Dx_valid           - registered read word and valid per FIFO
//   Dx_empty, Dx_full, Dx_almost_full - occupancy flags per FIFO
//   overflow_err, underflow_err       - sticky errors, OR of both FIFOs
module demux_destino
  import demux_destino_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              destiny,
  input  logic              pop_D0,
  input  logic              pop_D1,
  output logic [DATA_W-1:0] D0_out,
  output logic [DATA_W-1:0] D1_out,
  output logic              D0_valid,
  output logic              D1_valid,
  output logic              D0_empty,
  output logic              D1_empty,
  output logic              D0_full,
  output logic              D1_full,
  output logic              D0_almost_full,
  output logic              D1_almost_full,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic push_d0, push_d1;
  logic ovf_d0, ovf_d1, udf_d0, udf_d1;

  assign push_d0 = valid_in && !destiny;
  assign push_d1 = valid_in && destiny;

  fifo_destino #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF_THRESH)
  ) u_fifo_d0 (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_d0),
    .pop_i        (pop_D0),
    .data_i       (data_in),
    .data_o       (D0_out),
    .valid_o      (D0_valid),
    .empty_o      (D0_empty),
    .full_o       (D0_full),
    .almost_full_o(D0_almost_full),
    .overflow_o   (ovf_d0),
    .underflow_o  (udf_d0)
  );

  fifo_destino #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF_THRESH)
  ) u_fifo_d1 (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_d1),
    .pop_i        (pop_D1),
    .data_i       (data_in),
    .data_o       (D1_out),
    .valid_o      (D1_valid),
    .empty_o      (D1_empty),
    .full_o       (D1_full),
    .almost_full_o(D1_almost_full),
    .overflow_o   (ovf_d1),
    .underflow_o  (udf_d1)
  );

  assign overflow_err  = ovf_d0 || ovf_d1;
  assign underflow_err = udf_d0 || udf_d1;

endmodule

// File: doc/demux_destino.md
DEMUX_DESTINO -- requirements
Module: demux_destino

Interface
REQ-001 Parameter DATA_W, default 6, word width (bit 4 = destination bit).
REQ-002 Parameter DEPTH, default 4, entries per destination FIFO (power of two).
REQ-003 Parameter AF_THRESH, default 3, occupancy at or above which almost_full asserts.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 data_in  in  DATA_W  word from arbiter mux stage.
REQ-007 valid_in  in  1  data_in/destiny valid this cycle (registered pop-delay from arbiter stage).
REQ-008 destiny  in  1  0 selects D0, 1 selects D1.
REQ-009 pop_D0, pop_D1  in  1 each  consumer read requests.
REQ-010 D0_out, D1_out  out  DATA_W each  registered read data.
REQ-011 D0_valid, D1_valid  out  1 each  read data valid.
REQ-012 D0_empty, D1_empty, D0_full, D1_full  out  1 each  occupancy flags.
REQ-013 D0_almost_full, D1_almost_full  out  1 each  back-pressure to arbiter stage.
REQ-014 overflow_err, underflow_err  out  1 each  sticky error flags.

Function
REQ-015 valid_in=1 pushes data_in into D0 when destiny=0, into D1 when destiny=1; valid_in=0 pushes nothing.
REQ-016 destiny routing is evaluated same cycle as valid_in; data_in stored unmodified (all DATA_W bits).
REQ-017 Push in cycle N: entry written at edge N, empty deasserts and count increments visible cycle N+1.
REQ-018 pop_Dx with FIFO non-empty in cycle N: Dx_out holds head word and Dx_valid=1 in cycle N+1; otherwise Dx_valid=0 and Dx_out holds last value.
REQ-019 Read/write pointers are log2(DEPTH) bits, wrap DEPTH-1 -> 0; occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-020 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); all combinational from registered count.
REQ-021 Push to full FIFO without same-cycle pop: word dropped, pointers/count unchanged, overflow_err set.
REQ-022 Push to full FIFO with same-cycle pop: both accepted, count unchanged, no error.
REQ-023 Pop on empty FIFO: ignored, Dx_valid=0, underflow_err set.
REQ-024 Push and pop same cycle on empty FIFO: push accepted, pop treated as underflow (no bypass).
REQ-025 Simultaneous push and pop, non-empty non-full: count unchanged, both pointers advance.
REQ-026 D0 and D1 operate independently; activity on one never alters the other.
REQ-027 overflow_err/underflow_err remain 1 until reset.

Reset
REQ-028 reset=1 at a rising edge clears pointers, counts, Dx_out=0, Dx_valid=0, overflow_err=0, underflow_err=0; FIFOs read empty=1, full=0, almost_full=0 the following cycle.
REQ-029 Reset mid-operation discards all stored words; push/pop inputs during reset are ignored.
REQ-030 Storage array contents need not be cleared; only control state is reset.

Structure
REQ-031 DATA_W, DEPTH, AF_THRESH defaults and the destination-bit index (4) live in the shared transmit-layer constants package.
REQ-032 One sub-module fifo_destino (single FIFO with flags/errors), instantiated twice; demux_destino holds routing and error OR-ing.

Verification
REQ-033 Reset, then push 0x05 (destiny=0) -> next cycle D0_empty=0, D1_empty=1; pop_D0 -> D0_out=0x05, D0_valid=1 one cycle later.
REQ-034 Push 0x10,0x11,0x12,0x13 (bit4=1, destiny=1) -> D1_almost_full=1 after third, D1_full=1 after fourth; pops return 0x10..0x13 in order.
REQ-035 Fill D0 (4 words), push 0x0A without pop -> word dropped, overflow_err=1; repeat with pop_D0 same cycle -> accepted, no new error.
REQ-036 pop_D1 on empty D1 -> D1_valid=0, underflow_err=1 and stays 1 until reset.
REQ-037 Interleave 8 pushes alternating destiny with continuous pops -> pointers wrap, order preserved per destination, no errors.
REQ-038 Assert reset with D0 holding 3 words -> next cycle D0_empty=1, count 0, error flags 0, D0_valid=0.
